// File: rtl/pll_lock_reset_seq.sv
// pll_lock_reset_seq
//   Runs on the PLL output clock. Synchronises the raw PLL LOCK flag, waits for
//   it to stay high for STABLE_CYCLES, keeps the system reset asserted for a
//   further RESET_HOLD cycles while the CPU clock enables already run, and then
//   releases the reset. When lock drops in RUN, the block re-asserts reset and
//   counts the loss in a saturating 8-bit counter.
//
// Ports
//   clk            in   PLL output clock, rising edge
//   reset          in   asynchronous active-high reset
//   pll_lock       in   raw PLL LOCK, asynchronous to clk
//   sys_reset      out  registered active-high system reset
//   ready          out  high only while in RUN
//   ce_e           out  one-cycle E enable, once every CE_DIV cycles
//   ce_q           out  one-cycle Q enable, CE_DIV/2 cycles after ce_e
//   lock_lost_cnt  out  saturating count of lock losses seen in RUN
module pll_lock_reset_seq #(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 1024,
    parameter int RESET_HOLD    = 16,
    parameter int CE_DIV        = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pll_lock,
    output logic       sys_reset,
    output logic       ready,
    output logic       ce_e,
    output logic       ce_q,
    output logic [7:0] lock_lost_cnt
);

    localparam int CNT_MAX = (STABLE_CYCLES > RESET_HOLD) ? STABLE_CYCLES : RESET_HOLD;
    localparam int CNT_W   = $clog2(CNT_MAX);
    localparam int DIV_W   = $clog2(CE_DIV);

    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(RESET_HOLD - 1);
    localparam logic [DIV_W-1:0] DIV_LAST    = DIV_W'(CE_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_HALF    = DIV_W'(CE_DIV / 2 - 1);

    typedef enum logic [1:0] {
        WAIT_LOCK,
        STABLE,
        HOLD,
        RUN
    } state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [DIV_W-1:0]       div_q, div_d;
    logic [7:0]             lost_q, lost_d;
    logic                   sys_reset_q, ready_q, ce_e_q, ce_q_q;
    logic                   lock_s;
    logic                   en_now, en_next;
    logic                   ce_e_d, ce_q_d;

    assign lock_s = sync_q[SYNC_STAGES-1];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        lost_d  = lost_q;
        case (state_q)
            WAIT_LOCK: begin
                if (lock_s) begin
                    state_d = STABLE;
                    cnt_d   = '0;
                end
            end
            STABLE: begin
                if (!lock_s) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == STABLE_LAST) begin
                    state_d = HOLD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            HOLD: begin
                if (!lock_s) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == HOLD_LAST) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RUN: begin
                if (!lock_s) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                    if (lost_q != '1) begin
                        lost_d = lost_q + 8'd1;
                    end
                end
            end
            default: begin
                state_d = WAIT_LOCK;
                cnt_d   = '0;
            end
        endcase
    end

    // The divider advances only while staying inside HOLD/RUN, so it starts at
    // zero on entry to HOLD and keeps its phase across the HOLD->RUN release.
    // Enables are computed from next-state values so the registered pulses line
    // up with the div_cnt value of the same cycle.
    always_comb begin
        en_now  = (state_q == HOLD) || (state_q == RUN);
        en_next = (state_d == HOLD) || (state_d == RUN);
        div_d   = '0;
        if (en_now && en_next) begin
            div_d = (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);
        end
        ce_e_d = en_next && (div_d == DIV_LAST);
        ce_q_d = en_next && (div_d == DIV_HALF);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q      <= '0;
            state_q     <= WAIT_LOCK;
            cnt_q       <= '0;
            div_q       <= '0;
            lost_q      <= '0;
            sys_reset_q <= 1'b1;
            ready_q     <= 1'b0;
            ce_e_q      <= 1'b0;
            ce_q_q      <= 1'b0;
        end else begin
            sync_q      <= {sync_q[SYNC_STAGES-2:0], pll_lock};
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            div_q       <= div_d;
            lost_q      <= lost_d;
            sys_reset_q <= (state_d != RUN);
            ready_q     <= (state_d == RUN);
            ce_e_q      <= ce_e_d;
            ce_q_q      <= ce_q_d;
        end
    end

    assign sys_reset     = sys_reset_q;
    assign ready         = ready_q;
    assign ce_e          = ce_e_q;
    assign ce_q          = ce_q_q;
    assign lock_lost_cnt = lost_q;

endmodule

// File: tb/tb_pll_lock_reset_seq.sv
module tb_pll_lock_reset_seq;

    localparam int S  = 2;
    localparam int SC = 8;
    localparam int RH = 4;
    localparam int CD = 8;

    // Model thresholds: L = number of consecutive edges on which the FSM has
    // seen synced lock high. HOLD starts at L=SC+1, RUN at L=SC+RH+1.
    localparam int HOLD_L = SC + 1;
    localparam int RUN_L  = SC + RH + 1;

    logic       clk = 1'b0;
    logic       reset;
    logic       pll_lock;
    logic       sys_reset, ready, ce_e, ce_q;
    logic [7:0] lock_lost_cnt;

    pll_lock_reset_seq #(
        .SYNC_STAGES  (S),
        .STABLE_CYCLES(SC),
        .RESET_HOLD   (RH),
        .CE_DIV       (CD)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .pll_lock     (pll_lock),
        .sys_reset    (sys_reset),
        .ready        (ready),
        .ce_e         (ce_e),
        .ce_q         (ce_q),
        .lock_lost_cnt(lock_lost_cnt)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Behavioural reference
    logic mq[$];
    int   L;
    int   lost;

    typedef struct {
        logic       lock;
        logic       sr;
        logic       rdy;
        logic       e;
        logic       q;
        logic [7:0] lost;
    } vec_t;

    vec_t tbl[24];

    task automatic model_reset();
        mq.delete();
        for (int i = 0; i < S; i++) mq.push_back(1'b0);
        L    = 0;
        lost = 0;
    endtask

    task automatic model_edge(input logic v);
        logic obs;
        obs = mq.pop_front();
        mq.push_back(v);
        if (obs) begin
            L++;
        end else begin
            if (L >= RUN_L && lost < 255) lost++;
            L = 0;
        end
    endtask

    function automatic int model_out();
        logic e, q;
        e = (L >= HOLD_L) && (((L - HOLD_L) % CD) == CD - 1);
        q = (L >= HOLD_L) && (((L - HOLD_L) % CD) == CD / 2 - 1);
        return {20'd0, (L < RUN_L), (L >= RUN_L), e, q, lost[7:0]};
    endfunction

    function automatic int dut_out();
        return {20'd0, sys_reset, ready, ce_e, ce_q, lock_lost_cnt};
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic edge_only(input logic v);
        pll_lock = v;
        @(posedge clk);
        model_edge(v);
        #1;
    endtask

    task automatic step(input logic v, input string name);
        edge_only(v);
        chk(name, dut_out(), model_out());
    endtask

    // Asserted away from the clock edge; outputs must react before any edge.
    task automatic async_reset();
        reset = 1'b1;
        #1;
        model_reset();
        chk("async_reset", dut_out(), model_out());
        @(posedge clk);
        #1;
        chk("reset_held", dut_out(), model_out());
        reset = 1'b0;
    endtask

    initial begin
        int at;
        int ne, nq;
        logic cur;
        int r;

        reset    = 1'b1;
        pll_lock = 1'b0;

        // Expected trace with lock tied high; entry i is edge i+1 after
        // stage 1 first samples 1.
        for (int i = 0; i < 24; i++) begin
            tbl[i] = '{lock: 1'b1, sr: 1'b1, rdy: 1'b0, e: 1'b0, q: 1'b0, lost: 8'd0};
            if (i + 1 >= 15) begin
                tbl[i].sr  = 1'b0;
                tbl[i].rdy = 1'b1;
            end
            if (i + 1 == 14 || i + 1 == 22) tbl[i].q = 1'b1;
            if (i + 1 == 18) tbl[i].e = 1'b1;
        end

        #2;
        async_reset();
        for (int i = 0; i < 3; i++) step(1'b0, "idle");

        // 1) release latency / first enables
        for (int i = 0; i < 24; i++) begin
            edge_only(tbl[i].lock);
            chk($sformatf("table_e%0d", i + 1), dut_out(),
                {20'd0, tbl[i].sr, tbl[i].rdy, tbl[i].e, tbl[i].q, tbl[i].lost});
        end

        // 3) loss in RUN: reset 3 edges after drop, re-release 15 after rise
        at = 0;
        for (int k = 1; k <= 10; k++) begin
            step(1'b0, "loss");
            if (at == 0 && sys_reset) at = k;
        end
        chk("loss_latency", at, 3);
        chk("loss_count", lock_lost_cnt, 1);
        at = 0;
        for (int k = 1; k <= 40; k++) begin
            step(1'b1, "relock");
            if (at == 0 && !sys_reset) at = k;
        end
        chk("relock_latency", at, 15);

        // 4) enables over 64 cycles in RUN
        ne = 0;
        nq = 0;
        for (int k = 0; k < 64; k++) begin
            step(1'b1, "run_en");
            if (ce_e) ne++;
            if (ce_q) nq++;
            if (ce_e && ce_q) chk("ce_overlap", 1, 0);
        end
        chk("ce_e_count", ne, 8);
        chk("ce_q_count", nq, 8);

        // 2) lock drop during STABLE restarts the count, no loss counted
        async_reset();
        for (int k = 0; k < 5; k++) step(1'b1, "glitch_hi");
        for (int k = 0; k < 3; k++) step(1'b0, "glitch_lo");
        at = 0;
        for (int k = 1; k <= 40; k++) begin
            step(1'b1, "glitch_relock");
            if (at == 0 && ready) at = k;
        end
        chk("glitch_release", at, 15);
        chk("glitch_no_loss", lock_lost_cnt, 0);

        // 6) reset during HOLD
        async_reset();
        for (int k = 0; k < 12; k++) step(1'b1, "to_hold");
        async_reset();
        for (int k = 0; k < 3; k++) step(1'b0, "post_reset");

        // 5) 300 losses saturate the counter
        for (int k = 0; k < 16; k++) step(1'b1, "sat_start");
        for (int n = 0; n < 300; n++) begin
            step(1'b0, "sat_drop");
            for (int k = 0; k < 14; k++) step(1'b1, "sat_hi");
        end
        for (int k = 0; k < 3; k++) step(1'b1, "sat_tail");
        chk("lost_saturated", lock_lost_cnt, 255);

        // Randomized lock behaviour with occasional async reset
        async_reset();
        cur = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            r = $urandom_range(0, 199);
            if (r < 1) begin
                async_reset();
            end else begin
                if (r < 6) cur = ~cur;
                else if (r < 10) step(~cur, "rand_glitch");
                step(cur, "random");
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
